// File: rtl/park_pkg.sv
// rtl/park_pkg.sv - shared sizing, channel state type and slot-to-bit mapping
package park_pkg;
  localparam int SLOTS = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_LOW} chan_state_e;

  // Slot 0 lives in the MSB of the occupancy vector.
  function automatic int slot_bit(input int idx, input int slots = SLOTS);
    return slots - 1 - idx;
  endfunction
endpackage

// File: rtl/park_space_tracker_if.sv
// rtl/park_space_tracker_if.sv - entry/exit request channels and occupancy status bundle
interface park_space_tracker_if;
  import park_pkg::*;

  logic             entry_req;
  logic [IDX_W-1:0] entry_slot;
  logic             exit_req;
  logic [IDX_W-1:0] exit_slot;
  logic [SLOTS-1:0] parking_capacity;
  logic [CNT_W-1:0] free_count;
  logic             full;
  logic             empty;
  logic             entry_ack;
  logic             entry_err;
  logic             exit_ack;
  logic             exit_err;

  modport master (
    output entry_req, entry_slot, exit_req, exit_slot,
    input  parking_capacity, free_count, full, empty,
    input  entry_ack, entry_err, exit_ack, exit_err
  );

  modport slave (
    input  entry_req, entry_slot, exit_req, exit_slot,
    output parking_capacity, free_count, full, empty,
    output entry_ack, entry_err, exit_ack, exit_err
  );
endinterface

// File: rtl/park_req_channel.sv
// rtl/park_req_channel.sv - level req/ack channel FSM; captures the slot and strobes go once per request
module park_req_channel
  import park_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_i,
  input  logic [IDX_W-1:0] slot_i,
  output logic             go_o,
  output logic [IDX_W-1:0] slot_o
);
  chan_state_e      state_q, state_d;
  logic [IDX_W-1:0] slot_q, slot_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          slot_d  = slot_i;
          state_d = BUSY;
        end
      end
      BUSY:     state_d = WAIT_LOW;
      WAIT_LOW: if (!req_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Reset landing on the BUSY cycle suppresses the strobe so no ack escapes.
  always_comb begin
    go_o = (state_q == BUSY) && !reset;
  end

  assign slot_o = slot_q;
endmodule

// File: rtl/park_space_tracker.sv
// rtl/park_space_tracker.sv - occupancy register with entry/exit channels, free count and full/empty flags
module park_space_tracker
  import park_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  park_space_tracker_if.slave  bus
);
  logic [SLOTS-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ent_go, ext_go;
  logic [IDX_W-1:0] ent_idx, ext_idx;
  logic             ent_ok, ext_ok;

  park_req_channel u_entry (
    .clk    (clk),
    .reset  (reset),
    .req_i  (bus.entry_req),
    .slot_i (bus.entry_slot),
    .go_o   (ent_go),
    .slot_o (ent_idx)
  );

  park_req_channel u_exit (
    .clk    (clk),
    .reset  (reset),
    .req_i  (bus.exit_req),
    .slot_i (bus.exit_slot),
    .go_o   (ext_go),
    .slot_o (ext_idx)
  );

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < SLOTS;
  endfunction

  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
    return IDX_W'(slot_bit(int'(idx)));
  endfunction

  // Both checks look at the pre-update vector, so a same-slot collision
  // resolves itself: only the request matching the current state succeeds.
  always_comb begin
    ent_ok = ent_go && in_range(ent_idx) && cap_q[bit_pos(ent_idx)];
    ext_ok = ext_go && in_range(ext_idx) && !cap_q[bit_pos(ext_idx)];
    cap_d  = cap_q;
    if (ent_ok) cap_d[bit_pos(ent_idx)] = 1'b0;
    if (ext_ok) cap_d[bit_pos(ext_idx)] = 1'b1;
    cnt_d  = cnt_q - CNT_W'(ent_ok) + CNT_W'(ext_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '1;
      cnt_q <= CNT_W'(SLOTS);
    end else begin
      cap_q <= cap_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.parking_capacity = cap_q;
  assign bus.free_count       = cnt_q;
  assign bus.full             = (cnt_q == '0);
  assign bus.empty            = (cnt_q == CNT_W'(SLOTS));
  assign bus.entry_ack        = ent_go;
  assign bus.entry_err        = ent_go && !ent_ok;
  assign bus.exit_ack         = ext_go;
  assign bus.exit_err         = ext_go && !ext_ok;
endmodule

// File: tb/tb_park_space_tracker.sv
// tb/tb_park_space_tracker.sv - scoreboard bench: directed requests queue expected acks and resulting occupancy
module tb_park_space_tracker;
  typedef struct {
    logic       ea;
    logic       ee;
    logic       xa;
    logic       xe;
    logic [7:0] cap;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  park_space_tracker_if bus ();

  park_space_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t mk(input logic ea, input logic ee, input logic xa, input logic xe,
                              input logic [7:0] cap, input logic [3:0] cnt);
    exp_t e;
    e.ea = ea; e.ee = ee; e.xa = xa; e.xe = xe; e.cap = cap; e.cnt = cnt;
    return e;
  endfunction

  task automatic check_state(input string name, input logic [7:0] cap, input logic [3:0] cnt);
    logic rf, re;
    rf = (cnt == 4'd0);
    re = (cnt == 4'd8);
    checks++;
    if (bus.parking_capacity !== cap || bus.free_count !== cnt || bus.full !== rf || bus.empty !== re) begin
      failures++;
      $display("FAIL %s cap=%b cnt=%0d full=%b empty=%b required cap=%b cnt=%0d full=%b empty=%b",
               name, bus.parking_capacity, bus.free_count, bus.full, bus.empty, cap, cnt, rf, re);
    end
  endtask

  task automatic check_static(input string name, input logic [7:0] cap, input logic [3:0] cnt);
    check_state(name, cap, cnt);
    checks++;
    if ({bus.entry_ack, bus.entry_err, bus.exit_ack, bus.exit_err} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_acks got=%b required=0000", name,
               {bus.entry_ack, bus.entry_err, bus.exit_ack, bus.exit_err});
    end
  endtask

  // Monitor: every ack cycle pops one expectation; occupancy is checked a cycle later.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (bus.entry_ack === 1'b1 || bus.exit_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack got=%b required=none",
                   {bus.entry_ack, bus.entry_err, bus.exit_ack, bus.exit_err});
        end else begin
          ex = exp_q.pop_front();
          if ({bus.entry_ack, bus.entry_err, bus.exit_ack, bus.exit_err} !== {ex.ea, ex.ee, ex.xa, ex.xe}) begin
            failures++;
            $display("FAIL acks got=%b required=%b",
                     {bus.entry_ack, bus.entry_err, bus.exit_ack, bus.exit_err}, {ex.ea, ex.ee, ex.xa, ex.xe});
          end
          @(negedge clk);
          check_state("post_update", ex.cap, ex.cnt);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic txn(input string name, input bit e, input int es, input bit x, input int xs,
                     input int hold, input exp_t ex);
    exp_q.push_back(ex);
    @(negedge clk);
    bus.entry_req  = e;
    bus.entry_slot = 3'(es);
    bus.exit_req   = x;
    bus.exit_slot  = 3'(xs);
    repeat (hold) @(negedge clk);
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    wait_drain(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill_cap [8];
    fill_cap = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    bus.entry_req = 1'b0; bus.entry_slot = '0;
    bus.exit_req  = 1'b0; bus.exit_slot  = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_static("reset_idle", 8'hFF, 4'd8);

    txn("entry0_held", 1, 0, 0, 0, 6, mk(1, 0, 0, 0, 8'h7F, 4'd7));
    txn("entry0_again", 1, 0, 0, 0, 1, mk(1, 1, 0, 0, 8'h7F, 4'd7));
    txn("exit2_free", 0, 0, 1, 2, 2, mk(0, 0, 1, 1, 8'h7F, 4'd7));
    txn("both_diff", 1, 2, 1, 0, 2, mk(1, 0, 1, 0, 8'hDF, 4'd7));
    txn("both_same_occ", 1, 2, 1, 2, 2, mk(1, 1, 1, 0, 8'hFF, 4'd8));

    for (int k = 0; k < 8; k++)
      txn("fill", 1, k, 0, 0, 1, mk(1, 0, 0, 0, fill_cap[k], 4'(7 - k)));
    txn("entry_full", 1, 3, 0, 0, 1, mk(1, 1, 0, 0, 8'h00, 4'd0));
    txn("exit5", 0, 0, 1, 5, 1, mk(0, 0, 1, 0, 8'h04, 4'd1));
    txn("both_same_free", 1, 5, 1, 5, 1, mk(1, 0, 1, 1, 8'h00, 4'd0));

    do_reset();
    @(negedge clk);
    check_static("reset_again", 8'hFF, 4'd8);
    txn("exit_empty", 0, 0, 1, 7, 1, mk(0, 0, 1, 1, 8'hFF, 4'd8));
    txn("entry0_pre", 1, 0, 0, 0, 1, mk(1, 0, 0, 0, 8'h7F, 4'd7));

    // Reset lands on the BUSY cycle of an entry to slot 1; req stays high throughout.
    @(negedge clk);
    bus.entry_req  = 1'b1;
    bus.entry_slot = 3'd1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_static("reset_in_busy", 8'hFF, 4'd8);
    exp_q.push_back(mk(1, 0, 0, 0, 8'hBF, 4'd7));
    reset = 1'b0;
    repeat (4) @(negedge clk);
    bus.entry_req = 1'b0;
    wait_drain("held_after_reset");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
